// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding imem request feeding a DEPTH-entry FIFO of {pc+4, inst}.
// Define FETCH_QUEUE_BYPASS_EN to present an ack into an empty queue on the outputs in the same cycle.
module fetch_queue #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       redirect_i,
  input  logic [ADDR_W-1:0]          redirect_pc_i,
  output logic                       imem_req_o,
  output logic [ADDR_W-1:0]          imem_addr_o,
  input  logic                       imem_ack_i,
  input  logic [DATA_W-1:0]          imem_data_i,
  output logic                       valid_o,
  output logic [DATA_W-1:0]          inst_o,
  output logic [ADDR_W-1:0]          pc_o,
  input  logic                       take_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [DATA_W-1:0] mem_inst [DEPTH];

  logic              req_q, req_n, drop_q, drop_n;
  logic [ADDR_W-1:0] addr_q, addr_n, fetch_pc_q, fetch_pc_n;
  logic [PTR_W-1:0]  head_q, head_n, tail_q, tail_n;
  logic [CNT_W-1:0]  count_q, count_n;
  logic              valid_q, valid_n;
  logic [DATA_W-1:0] inst_q, inst_n;
  logic [ADDR_W-1:0] pc_q, pc_n;

  logic              ack_hit, ack_ok, bypass_c, bypass_take, push, pop, head_fresh;
  logic [ADDR_W-1:0] push_pc;

  // Next-state for request channel, queue pointers and registered head view
  always_comb begin
    ack_hit     = req_q && imem_ack_i;
    ack_ok      = ack_hit && !drop_q && !redirect_i;
    push_pc     = addr_q + ADDR_W'(4);
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_c    = ack_ok && (count_q == '0);
`else
    bypass_c    = 1'b0;
`endif
    bypass_take = bypass_c && take_i;
    pop         = take_i && valid_q && !redirect_i;
    push        = ack_ok && !bypass_take;

    head_n     = head_q;
    tail_n     = tail_q;
    count_n    = count_q;
    fetch_pc_n = fetch_pc_q;
    if (redirect_i) begin
      head_n     = '0;
      tail_n     = '0;
      count_n    = '0;
      fetch_pc_n = redirect_pc_i;
    end else begin
      if (pop)    head_n = head_q + PTR_W'(1);
      if (push)   tail_n = tail_q + PTR_W'(1);
      count_n = count_q + CNT_W'(push) - CNT_W'(pop);
      if (ack_ok) fetch_pc_n = fetch_pc_q + ADDR_W'(4);
    end

    // A request redirected away before its ack stays on the bus but is discarded
    drop_n = drop_q;
    req_n  = req_q;
    addr_n = addr_q;
    if (ack_hit) drop_n = 1'b0;
    if (redirect_i && req_q && !imem_ack_i) drop_n = 1'b1;
    if (!req_q || imem_ack_i) begin
      req_n = start_i && (count_n < DEPTH_C);
      if (req_n) addr_n = fetch_pc_n;
    end

    head_fresh = push && ((count_q - CNT_W'(pop)) == '0);
    valid_n    = 1'b0;
    inst_n     = '0;
    pc_n       = '0;
    if (count_n != '0) begin
      valid_n = 1'b1;
      if (head_fresh) begin
        inst_n = imem_data_i;
        pc_n   = push_pc;
      end else begin
        inst_n = mem_inst[head_n];
        pc_n   = mem_pc[head_n];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      req_q      <= 1'b0;
      drop_q     <= 1'b0;
      addr_q     <= '0;
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      inst_q     <= '0;
      pc_q       <= '0;
    end else begin
      req_q      <= req_n;
      drop_q     <= drop_n;
      addr_q     <= addr_n;
      fetch_pc_q <= fetch_pc_n;
      head_q     <= head_n;
      tail_q     <= tail_n;
      count_q    <= count_n;
      valid_q    <= valid_n;
      inst_q     <= inst_n;
      pc_q       <= pc_n;
    end
  end

  // Storage is not reset; entries are only read once written
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_pc[tail_q]   <= push_pc;
      mem_inst[tail_q] <= imem_data_i;
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign count_o     = count_q;
`ifdef FETCH_QUEUE_BYPASS_EN
  assign valid_o = valid_q | bypass_c;
  assign inst_o  = bypass_c ? imem_data_i : inst_q;
  assign pc_o    = bypass_c ? push_pc : pc_q;
`else
  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
`endif

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning fetch address and PC width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning queue entries; legal values are powers of two, 2..64.
REQ-004 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-005 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start_i  input  1  fetch enable; no new requests while low.
REQ-008 SHALL have port redirect_i  input  1  branch/jump taken; flush queue.
REQ-009 SHALL have port redirect_pc_i  input  ADDR_W  new fetch address.
REQ-010 SHALL have port imem_req_o  output  1  instruction memory request.
REQ-011 SHALL have port imem_addr_o  output  ADDR_W  request address.
REQ-012 SHALL have port imem_ack_i  input  1  request complete; data valid this cycle.
REQ-013 SHALL have port imem_data_i  input  DATA_W  returned instruction.
REQ-014 SHALL have port valid_o  output  1  head entry valid.
REQ-015 SHALL have port inst_o  output  DATA_W  head instruction.
REQ-016 SHALL have port pc_o  output  ADDR_W  head fetch address + 4.
REQ-017 SHALL have port take_i  input  1  decode consumes head when valid_o is high.
REQ-018 SHALL have port count_o  output  clog2(DEPTH+1)  occupied entries.

Function
- REQ-019 SHALL allow at most one outstanding request; imem_req_o and imem_addr_o SHALL stay stable until the cycle imem_ack_i is high; an ack in the request's first cycle is legal.
- REQ-020 SHALL raise imem_req_o only when start_i is high and count_o + outstanding < DEPTH, so a push never overflows.
- REQ-021 SHALL, on an accepted ack (not marked drop), push {imem_addr_o+4, imem_data_i} at the tail and advance the fetch PC by 4, wrapping modulo 2^ADDR_W.
- REQ-022 SHALL pop the head on take_i && valid_o; take_i with valid_o low SHALL be ignored.
- REQ-023 SHALL support push and pop in the same cycle; count_o is then unchanged.
- REQ-024 SHALL, on redirect_i, empty the queue at the next edge, load the fetch PC with redirect_pc_i, and ignore take_i and any ack that cycle.
- REQ-025 SHALL, if a request is outstanding during redirect_i, mark it drop and discard its ack; the first new request issues the cycle after that ack.
- REQ-026 SHALL, for back-to-back redirects, let the latest redirect_pc_i win.
- REQ-027 SHALL give a minimum latency of 1 cycle from ack to valid_o when the queue is empty.
- REQ-028 SHALL make pointers log2(DEPTH) bits wide, wrapping naturally; count_o SHALL equal tail-head occupancy, 0..DEPTH.
- REQ-029 SHALL, with start_i low, finish the outstanding request and keep the queue contents.

Reset
- REQ-030 SHALL, with rst_i low, asynchronously clear imem_req_o=0, valid_o=0, count_o=0, drop flag=0, pointers=0, inst_o=0, pc_o=0, and set the fetch PC to RESET_PC.
- REQ-031 SHALL, on reset mid-request, abandon the request; an ack during reset SHALL be ignored.
- REQ-032 SHALL issue the first request no earlier than the first edge after rst_i rises with start_i high.

Configuration
- REQ-033 SHALL provide macro FETCH_QUEUE_BYPASS_EN.
  - Defined: when the queue is empty and an accepted ack arrives, valid_o/inst_o/pc_o SHALL present imem_data_i combinationally the same cycle. A take_i that cycle consumes it without a push.
  - Undefined: no combinational path from imem_* to the outputs; REQ-027 latency applies.

Verification
- REQ-034 SHALL cover: reset, start_i=1, ack 1 cycle after each request, take_i=1 -> imem_addr_o 0,4,8,...; pc_o 4,8,12; count_o never exceeds 1.
- REQ-035 SHALL cover: take_i=0, DEPTH=4, immediate acks -> count_o reaches 4, imem_req_o low, fetch PC=16; one take_i -> request for 16 resumes.
- REQ-036 SHALL cover: redirect_i with redirect_pc_i=0x100 while a request for 0x8 is outstanding, ack after 3 cycles -> ack data dropped, count_o=0, next imem_addr_o=0x100.
- REQ-037 SHALL cover: count_o=2 with simultaneous ack and take_i -> count_o stays 2, head advances, new entry at tail.
- REQ-038 SHALL cover: rst_i low mid-request with count_o=3 -> outputs zero immediately; after release, first imem_addr_o=RESET_PC.
- REQ-039 SHALL cover: redirect_pc_i=0xFFFFFFFC (ADDR_W=32) -> pc_o=0x0, next fetch 0x0.
